// File: rtl/acc_buf.sv
// Accumulation buffer feeding the ppu: sums partial-sum passes into a
// ROWS x LANES tile of saturating accumulators, then drains it one row per cycle.

module acc_buf_lane #(
    parameter int ROWS   = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24,
    parameter int RP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_first,
    input  logic [RP_W-1:0]   wr_row,
    input  logic [PSUM_W-1:0] psum,
    input  logic              rd_en,
    input  logic [RP_W-1:0]   rd_row,
    output logic [ACC_W-1:0]  rd_data,
    output logic              sat
);
    logic [ACC_W-1:0] mem [ROWS];
    logic [ACC_W:0]   psum_x;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] wr_val;

    assign psum_x = {{(ACC_W + 1 - PSUM_W){psum[PSUM_W-1]}}, psum};

    // Sum carries one guard bit; guard != sign means the result left the ACC_W range.
    always_comb begin
        sum    = {mem[wr_row][ACC_W-1], mem[wr_row]} + psum_x;
        wr_val = psum_x[ACC_W-1:0];
        sat    = 1'b0;
        if (!wr_first) begin
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                sat    = wr_en;
                wr_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                wr_val = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_row] <= wr_val;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_row];
        else
            rd_data <= '0;
    end
endmodule

module acc_buf #(
    parameter int LANES  = 16,
    parameter int ROWS   = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 24,
    parameter int GAP    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_psum_valid,
    input  logic [LANES*PSUM_W-1:0] i_psum_data,
    input  logic                    i_psum_first,
    input  logic                    i_psum_last,
    output logic                    o_ready,
    output logic                    o_ppu_start,
    output logic [LANES*ACC_W-1:0]  o_acc_data,
    output logic                    o_sat,
    output logic                    o_drop
);
    localparam int RP_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_MAX = (ROWS > GAP) ? ROWS : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {ACCUM, START, DRAIN, HOLD} state_t;

    state_t                         state, state_d;
    logic [CNT_W-1:0]               cnt, cnt_d;
    logic [RP_W-1:0]                rptr, rd_row;
    logic                           accept, tile_done, rd_en, start_d;
    logic [LANES-1:0]               lane_sat;
    logic [LANES-1:0][PSUM_W-1:0]   psum;
    logic [LANES-1:0][ACC_W-1:0]    acc;

    assign psum       = i_psum_data;
    assign o_acc_data = acc;
    assign accept     = i_psum_valid & o_ready;
    assign tile_done  = accept & i_psum_last & (rptr == RP_W'(ROWS - 1));

    // DRAIN counts 1..ROWS: row 0 is fetched on the START edge, so the
    // counter already points at the next row while the current one is on the bus.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rd_en   = 1'b0;
        rd_row  = '0;
        start_d = 1'b0;
        case (state)
            ACCUM: begin
                cnt_d = '0;
                if (tile_done) begin
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                rd_en   = 1'b1;
                cnt_d   = CNT_W'(1);
                state_d = DRAIN;
            end
            DRAIN: begin
                if (cnt == CNT_W'(ROWS)) begin
                    cnt_d   = '0;
                    state_d = (GAP == 0) ? ACCUM : HOLD;
                end else begin
                    rd_en  = 1'b1;
                    rd_row = cnt[RP_W-1:0];
                    cnt_d  = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = ACCUM;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ACCUM;
            cnt         <= '0;
            rptr        <= '0;
            o_ready     <= 1'b0;
            o_ppu_start <= 1'b0;
            o_sat       <= 1'b0;
            o_drop      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            o_ready     <= (state_d == ACCUM);
            o_ppu_start <= start_d;
            if (accept)
                rptr <= (rptr == RP_W'(ROWS - 1)) ? '0 : rptr + 1'b1;
            if (|lane_sat)
                o_sat <= 1'b1;
            if (i_psum_valid & ~o_ready)
                o_drop <= 1'b1;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        acc_buf_lane #(
            .ROWS   (ROWS),
            .PSUM_W (PSUM_W),
            .ACC_W  (ACC_W),
            .RP_W   (RP_W)
        ) u_lane (
            .clk      (i_clk),
            .rst      (i_rst),
            .wr_en    (accept),
            .wr_first (i_psum_first),
            .wr_row   (rptr),
            .psum     (psum[l]),
            .rd_en    (rd_en),
            .rd_row   (rd_row),
            .rd_data  (acc[l]),
            .sat      (lane_sat[l])
        );
    end
endmodule
